// File: rtl/ctrl_pkg.sv
// Shared definitions for the multicycle control unit: state encodings,
// opcode constants, instruction classes and ALU operation codes.
package ctrl_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        WB_ALU   = 4'd4,
        MEM_ADDR = 4'd5,
        MEM_RD   = 4'd6,
        MEM_WB   = 4'd7,
        MEM_WR   = 4'd8,
        BRANCH   = 4'd9,
        JUMP     = 4'd10,
        TRAP     = 4'd15
    } state_t;

    typedef enum logic [3:0] {
        CLS_R, CLS_IALU, CLS_LUI, CLS_LW, CLS_SW, CLS_SWB,
        CLS_BEQ, CLS_BNE, CLS_J, CLS_ILLEGAL
    } op_class_t;

    localparam logic [5:0] OP_RTYPE   = 6'b000000;
    localparam logic [5:0] OP_IALU_LO = 6'b001000;
    localparam logic [5:0] OP_IALU_HI = 6'b001110;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;
    localparam logic [5:0] OP_SWB     = 6'b101000;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_J       = 6'b000010;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_FUNCT = 4'd2;
    localparam logic [3:0] ALU_AND   = 4'd3;
    localparam logic [3:0] ALU_OR    = 4'd4;
    localparam logic [3:0] ALU_XOR   = 4'd5;
    localparam logic [3:0] ALU_SLT   = 4'd6;

    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_REG  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;
    localparam logic [1:0] SRCB_BOFF = 2'b11;

    // Immediate ALU ops follow the MIPS low opcode bits: addi/addiu, slti/sltiu, andi, ori, xori.
    function automatic logic [3:0] imm_alu_op(input logic [2:0] f);
        case (f)
            3'b010, 3'b011: imm_alu_op = ALU_SLT;
            3'b100:         imm_alu_op = ALU_AND;
            3'b101:         imm_alu_op = ALU_OR;
            3'b110:         imm_alu_op = ALU_XOR;
            default:        imm_alu_op = ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/op_decode.sv
// Combinational opcode-to-instruction-class decode.
module op_decode
    import ctrl_pkg::*;
(
    input  logic [5:0] op,
    output op_class_t  op_class
);

    always_comb begin
        op_class = CLS_ILLEGAL;
        if (op == OP_RTYPE)                           op_class = CLS_R;
        else if (op >= OP_IALU_LO && op <= OP_IALU_HI) op_class = CLS_IALU;
        else if (op == OP_LUI)                        op_class = CLS_LUI;
        else if (op == OP_LW)                         op_class = CLS_LW;
        else if (op == OP_SW)                         op_class = CLS_SW;
        else if (op == OP_SWB)                        op_class = CLS_SWB;
        else if (op == OP_BEQ)                        op_class = CLS_BEQ;
        else if (op == OP_BNE)                        op_class = CLS_BNE;
        else if (op == OP_J)                          op_class = CLS_J;
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle MIPS-style control FSM with a memory wait counter that traps
// when mem_ready does not arrive within MEM_TIMEOUT cycles.
module multicycle_ctrl
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [3:0] state,
    output logic [3:0] next_state,
    output logic       PCWrite,
    output logic       Branch,
    output logic       BranchType,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       ALUSrcA,
    output logic       RegWrite,
    output logic       LUI,
    output logic       SWB,
    output logic       trap,
    output logic [1:0] PCSource,
    output logic [1:0] ALUSrcB,
    output logic [3:0] ALUOp
);

    localparam logic [7:0] WAIT_LAST = 8'(MEM_TIMEOUT - 1);

    state_t    state_r, state_n;
    op_class_t op_class;
    logic [7:0] wait_cnt;
    logic       waiting, timeout, is_lui, is_swb;

    op_decode u_op_decode (
        .op       (op),
        .op_class (op_class)
    );

    assign state      = state_r;
    assign next_state = state_n;
    assign waiting    = (state_r == FETCH) || (state_r == MEM_RD) || (state_r == MEM_WR);
    // This cycle is the MEM_TIMEOUT-th without mem_ready; only matters when mem_ready is low.
    assign timeout    = (wait_cnt == WAIT_LAST);
    assign is_lui     = (op_class == CLS_LUI);
    assign is_swb     = (op_class == CLS_SWB);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_r <= FETCH;
        else        state_r <= state_n;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                    wait_cnt <= '0;
        else if (state_n != state_r)   wait_cnt <= '0;
        else if (waiting && !mem_ready) wait_cnt <= wait_cnt + 8'd1;
    end

    always_comb begin
        state_n = state_r;
        case (state_r)
            FETCH:    if (mem_ready) state_n = DECODE;
                      else if (timeout) state_n = TRAP;
            DECODE: begin
                case (op_class)
                    CLS_R:                    state_n = EXEC_R;
                    CLS_IALU, CLS_LUI:        state_n = EXEC_I;
                    CLS_LW, CLS_SW, CLS_SWB:  state_n = MEM_ADDR;
                    CLS_BEQ, CLS_BNE:         state_n = BRANCH;
                    CLS_J:                    state_n = JUMP;
                    default:                  state_n = TRAP;
                endcase
            end
            EXEC_R, EXEC_I: state_n = WB_ALU;
            WB_ALU:         state_n = FETCH;
            MEM_ADDR:       state_n = (op_class == CLS_LW) ? MEM_RD : MEM_WR;
            MEM_RD:   if (mem_ready) state_n = MEM_WB;
                      else if (timeout) state_n = TRAP;
            MEM_WB:         state_n = FETCH;
            MEM_WR:   if (mem_ready) state_n = FETCH;
                      else if (timeout) state_n = TRAP;
            BRANCH, JUMP:   state_n = FETCH;
            TRAP:           state_n = TRAP;
            default:        state_n = TRAP;
        endcase
    end

    always_comb begin
        PCWrite    = 1'b0;
        Branch     = 1'b0;
        BranchType = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        IRWrite    = 1'b0;
        MemtoReg   = 1'b0;
        ALUSrcA    = 1'b0;
        RegWrite   = 1'b0;
        LUI        = 1'b0;
        SWB        = 1'b0;
        trap       = 1'b0;
        PCSource   = PC_SEQ;
        ALUSrcB    = SRCB_REG;
        ALUOp      = ALU_ADD;
        case (state_r)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = SRCB_FOUR;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
            end
            DECODE:   ALUSrcB = SRCB_BOFF;
            EXEC_R: begin
                ALUSrcA = 1'b1;
                ALUOp   = ALU_FUNCT;
            end
            EXEC_I: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                ALUOp   = imm_alu_op(op[2:0]);
                LUI     = is_lui;
            end
            WB_ALU: begin
                RegWrite = 1'b1;
                LUI      = is_lui;
            end
            MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
            end
            MEM_RD:   MemRead = 1'b1;
            MEM_WB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            MEM_WR: begin
                MemWrite = 1'b1;
                SWB      = is_swb;
            end
            BRANCH: begin
                ALUSrcA    = 1'b1;
                ALUOp      = ALU_SUB;
                Branch     = 1'b1;
                BranchType = op[0];
                PCSource   = PC_BRANCH;
                PCWrite    = zero ^ op[0];
            end
            JUMP: begin
                PCWrite  = 1'b1;
                PCSource = PC_JUMP;
            end
            TRAP:     trap = 1'b1;
            default: ;
        endcase
        // Strobes stay quiet for the whole time reset is held, not just at its edge.
        if (!reset) begin
            PCWrite  = 1'b0;
            IRWrite  = 1'b0;
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            RegWrite = 1'b0;
            trap     = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized and directed bench for multicycle_ctrl: a per-instruction reference
// model expands each instruction into the expected cycle-by-cycle control trace.
module tb_multicycle_ctrl;

    localparam int TO = 15;

    localparam int K_R = 0, K_I = 1, K_LUI = 2, K_LW = 3, K_SW = 4, K_SWB = 5;
    localparam int K_BEQ = 6, K_BNE = 7, K_J = 8, K_ILL = 9;

    typedef struct packed {
        logic       pcw, br, bt, mrd, mwr, irw, m2r, srca, rw, lui, swb, trp;
        logic [1:0] pcs, srcb;
        logic [3:0] aluop;
    } ctl_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [5:0] op = 6'd0;
    logic       zero = 1'b0;
    logic       mem_ready = 1'b1;
    logic [3:0] state, next_state;
    logic       PCWrite, Branch, BranchType, MemRead, MemWrite, IRWrite;
    logic       MemtoReg, ALUSrcA, RegWrite, LUI, SWB, trap;
    logic [1:0] PCSource, ALUSrcB;
    logic [3:0] ALUOp;
    logic [19:0] outs;

    int total = 0;
    int bad   = 0;

    logic [23:0] exp_q[$];
    logic        mr_q[$];

    multicycle_ctrl #(.MEM_TIMEOUT(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .state      (state),
        .next_state (next_state),
        .PCWrite    (PCWrite),
        .Branch     (Branch),
        .BranchType (BranchType),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .MemtoReg   (MemtoReg),
        .ALUSrcA    (ALUSrcA),
        .RegWrite   (RegWrite),
        .LUI        (LUI),
        .SWB        (SWB),
        .trap       (trap),
        .PCSource   (PCSource),
        .ALUSrcB    (ALUSrcB),
        .ALUOp      (ALUOp)
    );

    assign outs = {PCWrite, Branch, BranchType, MemRead, MemWrite, IRWrite, MemtoReg,
                   ALUSrcA, RegWrite, LUI, SWB, trap, PCSource, ALUSrcB, ALUOp};

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
        end
    endtask

    function automatic int class_of(input logic [5:0] o);
        case (o)
            6'b000000: class_of = K_R;
            6'b001000, 6'b001001, 6'b001010, 6'b001011,
            6'b001100, 6'b001101, 6'b001110: class_of = K_I;
            6'b001111: class_of = K_LUI;
            6'b100011: class_of = K_LW;
            6'b101011: class_of = K_SW;
            6'b101000: class_of = K_SWB;
            6'b000100: class_of = K_BEQ;
            6'b000101: class_of = K_BNE;
            6'b000010: class_of = K_J;
            default:   class_of = K_ILL;
        endcase
    endfunction

    // addi/addiu add, slti/sltiu compare, andi/ori/xori logic, lui passes through the adder.
    function automatic logic [3:0] imm_op_of(input logic [5:0] o);
        case (o)
            6'b001010, 6'b001011: imm_op_of = ctrl_pkg::ALU_SLT;
            6'b001100:            imm_op_of = ctrl_pkg::ALU_AND;
            6'b001101:            imm_op_of = ctrl_pkg::ALU_OR;
            6'b001110:            imm_op_of = ctrl_pkg::ALU_XOR;
            default:              imm_op_of = ctrl_pkg::ALU_ADD;
        endcase
    endfunction

    task automatic push(input logic mr, input logic [3:0] st, input ctl_t c);
        mr_q.push_back(mr);
        exp_q.push_back({st, c});
    endtask

    task automatic push_trap(input int n);
        ctl_t t;
        t = '0;
        t.trp = 1'b1;
        for (int i = 0; i < n; i++) push(1'(($urandom)), 4'd15, t);
    endtask

    // A memory wait of k low cycles; TO consecutive lows end in a trap instead of completion.
    task automatic mem_phase(input logic [3:0] st, input int k, input ctl_t c,
                             input ctl_t c_done, output bit ok);
        int lows;
        lows = (k < TO) ? k : TO;
        for (int i = 0; i < lows; i++) push(1'b0, st, c);
        ok = (k < TO);
        if (ok) push(1'b1, st, c_done);
    endtask

    task automatic model_instr(input logic [5:0] o, input logic z, input int kf,
                               input int km, output bit trapped);
        ctl_t c, cd;
        bit ok;
        int k;
        k = class_of(o);
        trapped = 1'b0;
        c = '0; c.mrd = 1'b1; c.srcb = 2'b01; c.aluop = ctrl_pkg::ALU_ADD;
        cd = c; cd.irw = 1'b1; cd.pcw = 1'b1;
        mem_phase(4'd0, kf, c, cd, ok);
        if (!ok) begin
            push_trap(4);
            trapped = 1'b1;
            return;
        end
        c = '0; c.srcb = 2'b11; c.aluop = ctrl_pkg::ALU_ADD;
        push(1'(($urandom)), 4'd1, c);
        case (k)
            K_R: begin
                c = '0; c.srca = 1'b1; c.aluop = ctrl_pkg::ALU_FUNCT;
                push(1'(($urandom)), 4'd2, c);
                c = '0; c.rw = 1'b1;
                push(1'(($urandom)), 4'd4, c);
            end
            K_I, K_LUI: begin
                c = '0; c.srca = 1'b1; c.srcb = 2'b10; c.aluop = imm_op_of(o);
                c.lui = (k == K_LUI);
                push(1'(($urandom)), 4'd3, c);
                c = '0; c.rw = 1'b1; c.lui = (k == K_LUI);
                push(1'(($urandom)), 4'd4, c);
            end
            K_LW, K_SW, K_SWB: begin
                c = '0; c.srca = 1'b1; c.srcb = 2'b10; c.aluop = ctrl_pkg::ALU_ADD;
                push(1'(($urandom)), 4'd5, c);
                if (k == K_LW) begin
                    c = '0; c.mrd = 1'b1;
                    mem_phase(4'd6, km, c, c, ok);
                    if (ok) begin
                        c = '0; c.rw = 1'b1; c.m2r = 1'b1;
                        push(1'(($urandom)), 4'd7, c);
                    end
                end else begin
                    c = '0; c.mwr = 1'b1; c.swb = (k == K_SWB);
                    mem_phase(4'd8, km, c, c, ok);
                end
                if (!ok) begin
                    push_trap(4);
                    trapped = 1'b1;
                end
            end
            K_BEQ, K_BNE: begin
                c = '0; c.srca = 1'b1; c.aluop = ctrl_pkg::ALU_SUB; c.br = 1'b1;
                c.bt = (k == K_BNE); c.pcs = 2'b01;
                c.pcw = (k == K_BEQ) ? z : !z;
                push(1'(($urandom)), 4'd9, c);
            end
            K_J: begin
                c = '0; c.pcw = 1'b1; c.pcs = 2'b10;
                push(1'(($urandom)), 4'd10, c);
            end
            default: begin
                push_trap(4);
                trapped = 1'b1;
            end
        endcase
    endtask

    // Called at a falling edge; each step drives mem_ready, checks mid-cycle, moves to the next falling edge.
    task automatic run_plan(input int limit);
        int n;
        logic [23:0] e;
        n = 0;
        while (exp_q.size() > 0 && (limit < 0 || n < limit)) begin
            e = exp_q.pop_front();
            mem_ready = mr_q.pop_front();
            #2;
            check("state", 32'(state), 32'(e[23:20]));
            check("ctl", 32'(outs), 32'(e[19:0]));
            @(negedge clk);
            n++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        mem_ready = 1'b1;
        #1;
        check("rst_state", 32'(state), 32'd0);
        check("rst_strobes", 32'({PCWrite, IRWrite, MemRead, MemWrite, RegWrite, trap}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_hold_state", 32'(state), 32'd0);
        check("rst_hold_strobes", 32'({PCWrite, IRWrite, MemRead, MemWrite, RegWrite, trap}), 32'd0);
        exp_q.delete();
        mr_q.delete();
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic do_instr(input logic [5:0] o, input logic z, input int kf, input int km);
        bit t;
        op = o;
        zero = z;
        model_instr(o, z, kf, km, t);
        run_plan(-1);
        if (t) do_reset();
    endtask

    function automatic int pick_wait();
        if ($urandom_range(0, 9) == 0) pick_wait = $urandom_range(13, 16);
        else                           pick_wait = $urandom_range(0, 3);
    endfunction

    initial begin
        logic [5:0] legal[9];
        logic [5:0] o;
        bit t;
        legal[0] = 6'b000000; legal[1] = 6'b001000; legal[2] = 6'b001111;
        legal[3] = 6'b100011; legal[4] = 6'b101011; legal[5] = 6'b101000;
        legal[6] = 6'b000100; legal[7] = 6'b000101; legal[8] = 6'b000010;

        do_reset();

        do_instr(6'b000000, 1'b0, 0, 0);
        do_instr(6'b100011, 1'b0, 0, 3);
        do_instr(6'b000100, 1'b1, 0, 0);
        do_instr(6'b000101, 1'b1, 0, 0);
        do_instr(6'b000100, 1'b0, 1, 0);
        do_instr(6'b000101, 1'b0, 0, 0);
        do_instr(6'b101000, 1'b0, 2, 2);
        do_instr(6'b001111, 1'b0, 0, 0);
        do_instr(6'b001010, 1'b0, 0, 0);
        do_instr(6'b001101, 1'b0, 0, 0);
        do_instr(6'b000010, 1'b0, 0, 0);
        do_instr(6'b100011, 1'b0, 14, 14);
        do_instr(6'b101011, 1'b0, 0, 14);
        do_instr(6'b111111, 1'b0, 0, 0);
        do_instr(6'b000000, 1'b0, 15, 0);
        do_instr(6'b100011, 1'b0, 0, 15);
        do_instr(6'b101011, 1'b0, 1, 20);

        // Reset in the middle of a store wait: must drop MemWrite without a clock edge.
        op = 6'b101011;
        zero = 1'b0;
        model_instr(6'b101011, 1'b0, 0, 6, t);
        run_plan(5);
        #2;
        check("mid_wr_state", 32'(state), 32'd8);
        check("mid_wr_memwrite", 32'(MemWrite), 32'd1);
        do_reset();

        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 9) == 9) o = 6'($urandom);
            else                           o = legal[$urandom_range(0, 8)];
            if (o == 6'b001000) o = 6'($urandom_range(8, 14));
            do_instr(o, 1'($urandom), pick_wait(), pick_wait());
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
